pipe_stage_hs: RTL and testbench

//  Parametrised inter-stage pipeline register with valid/ready handshake, flush and optional 2-entry skid.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_skid_buf.sv | 73 +++++++
 rtl/pipe_stage_hs.sv | 92 +++++++++
 tb/tb_pipe_stage_hs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and default widths for the inter-stage pipeline
// registers of the pipelined ARM core.
//   ctrl_t       - decoded control bits carried down the pipe (bubble-safe)
//   id_ex_data_t - ID/EX payload: register tags, two operands, extended imm
//   CTRL_W, DATA_W, STALL_CW - default widths for pipe_stage_hs
package pipe_pkg;

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] flag_write;
        logic [2:0] alu_control;  // ALU op, compact encoding
        logic [3:0] cond;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  ra3;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] ext_imm;
    } id_ex_data_t;

    localparam int CTRL_W   = $bits(ctrl_t);        // 14
    localparam int DATA_W   = $bits(id_ex_data_t);  // 112
    localparam int STALL_CW = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry skid storage for pipe_stage_hs.
//   MAIN drives the stage outputs; SKB catches one beat accepted while MAIN
//   is stalled, so in_ready depends only on flop state.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               drop MAIN, SKB and the beat offered this cycle
//   in_valid/in_ctrl/in_data, in_ready   upstream side
//   out_ready           downstream accepts MAIN this cycle
//   main_valid/main_ctrl/main_data       MAIN entry contents
module pipe_skid_buf #(
    parameter int CTRL_W = 14,
    parameter int DATA_W = 112
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              main_valid,
    output logic [CTRL_W-1:0] main_ctrl,
    output logic [DATA_W-1:0] main_data
);

    logic              skb_valid;
    logic [CTRL_W-1:0] skb_ctrl;
    logic [DATA_W-1:0] skb_data;
    logic              accept;
    logic              drain;

    // Ready is purely a flop: no combinational path from out_ready.
    assign in_ready = !skb_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skb_valid  <= 1'b0;
            skb_ctrl   <= '0;
            skb_data   <= '0;
        end else if (flush) begin
            // Data flops hold; only validity and control are killed.
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skb_valid  <= 1'b0;
            skb_ctrl   <= '0;
        end else if (drain && skb_valid) begin
            // in_ready is low here, so no new beat competes for MAIN.
            main_valid <= 1'b1;
            main_ctrl  <= skb_ctrl;
            main_data  <= skb_data;
            skb_valid  <= 1'b0;
            skb_ctrl   <= '0;
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end
        end else if (accept) begin
            // MAIN stalled with a beat: park the new one behind it.
            skb_valid <= 1'b1;
            skb_ctrl  <= in_ctrl;
            skb_data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised inter-stage pipeline register with valid/ready
// handshake, flush, optional 2-entry skid and a saturating stall counter.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   flush                            kill held beats and the offered beat
//   in_valid, in_ready, in_ctrl, in_data      upstream handshake + beat
//   out_valid, out_ready, out_ctrl, out_data  downstream handshake + beat
//   stall_cnt                        cycles with out_valid && !out_ready
// out_ctrl is forced to zero whenever no beat is held, so a bubble can never
// leak write enables downstream.
module pipe_stage_hs #(
    parameter int CTRL_W   = pipe_pkg::CTRL_W,
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter bit SKID     = 1'b1,
    parameter int STALL_CW = pipe_pkg::STALL_CW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [DATA_W-1:0]   out_data,
    output logic [STALL_CW-1:0] stall_cnt
);
    import pipe_pkg::*;

    localparam logic [STALL_CW-1:0] STALL_MAX = '1;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk        (clk),
                .reset      (reset),
                .flush      (flush),
                .in_valid   (in_valid),
                .in_ctrl    (in_ctrl),
                .in_data    (in_data),
                .in_ready   (in_ready),
                .out_ready  (out_ready),
                .main_valid (main_valid),
                .main_ctrl  (main_ctrl),
                .main_data  (main_data)
            );
        end else begin : g_single
            // Single entry: can refill in the same cycle it drains.
            assign in_ready = !main_valid || out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    main_data  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (in_valid && in_ready) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= in_ctrl;
                    main_data  <= in_data;
                end else if (out_ready) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // Performance-debug counter; a flush cycle is not counted as a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;
    localparam int CW = 14;
    localparam int DW = 112;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    // shared stimulus for the two SKID=1 instances
    logic          in_valid, out_ready, flush;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          a_in_ready, a_out_valid, s_in_ready, s_out_valid;
    logic [CW-1:0] a_out_ctrl, s_out_ctrl;
    logic [DW-1:0] a_out_data, s_out_data;
    logic [15:0]   a_stall;
    logic [3:0]    s_stall;
    // stimulus for the SKID=0 instance
    logic          z_in_valid, z_out_ready, z_flush;
    logic [CW-1:0] z_in_ctrl;
    logic [DW-1:0] z_in_data;
    logic          z_in_ready, z_out_valid;
    logic [CW-1:0] z_out_ctrl;
    logic [DW-1:0] z_out_data;
    logic [15:0]   z_stall;

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .STALL_CW(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .STALL_CW(4)) dut_s (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data), .stall_cnt(s_stall));

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .STALL_CW(16)) dut_z (
        .clk(clk), .reset(reset), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_ctrl(z_in_ctrl), .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_ctrl(z_out_ctrl), .out_data(z_out_data), .stall_cnt(z_stall));

    // Reference model: the stage is a FIFO of held beats (capacity 2 with
    // skid, 1 without); head of the FIFO is what the outputs show.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;
    beat_t qa[$];
    beat_t qz[$];
    int    cnt_a, cnt_s, cnt_z;
    bit    known = 1'b0;
    int    checks = 0;
    int    failures = 0;

    typedef struct {
        logic          iv;
        logic [CW-1:0] c;
        logic          orr;
        logic          fl;
        logic          ov;
        logic [CW-1:0] oc;
        logic          ir;
        int            st;
    } vec_t;
    vec_t tv[$];

    function automatic logic [DW-1:0] dat_of(input logic [CW-1:0] c);
        return {8{c}};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare all instances against the model, away from the active edge.
    task automatic tick_pre();
        logic          ov, zov;
        logic [CW-1:0] oc, zoc;
        @(negedge clk);
        if (known) begin
            ov  = (qa.size() != 0);
            oc  = ov ? qa[0].c : '0;
            zov = (qz.size() != 0);
            zoc = zov ? qz[0].c : '0;
            chk("a_out_valid", 128'(a_out_valid), 128'(ov));
            chk("a_out_ctrl",  128'(a_out_ctrl),  128'(oc));
            chk("a_in_ready",  128'(a_in_ready),  128'(qa.size() < 2));
            chk("a_stall",     128'(a_stall),     128'(cnt_a));
            chk("s_out_valid", 128'(s_out_valid), 128'(ov));
            chk("s_out_ctrl",  128'(s_out_ctrl),  128'(oc));
            chk("s_stall",     128'(s_stall),     128'(cnt_s));
            if (ov) begin
                chk("a_out_data", 128'(a_out_data), 128'(qa[0].d));
                chk("s_out_data", 128'(s_out_data), 128'(qa[0].d));
            end
            chk("z_out_valid", 128'(z_out_valid), 128'(zov));
            chk("z_out_ctrl",  128'(z_out_ctrl),  128'(zoc));
            chk("z_in_ready",  128'(z_in_ready),  128'(!zov || z_out_ready));
            chk("z_stall",     128'(z_stall),     128'(cnt_z));
            if (zov) chk("z_out_data", 128'(z_out_data), 128'(qz[0].d));
        end
    endtask

    // Advance the model with the inputs the DUT is about to sample.
    task automatic tick_post();
        beat_t b;
        bit    a_has, z_has, a_rdy, z_rdy;
        if (reset) begin
            qa.delete(); qz.delete();
            cnt_a = 0; cnt_s = 0; cnt_z = 0;
            known = 1'b1;
        end else begin
            a_has = (qa.size() != 0);
            a_rdy = (qa.size() < 2);
            if (a_has && !out_ready && !flush) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_s < 15) cnt_s++;
            end
            if (flush) qa.delete();
            else begin
                if (a_has && out_ready) void'(qa.pop_front());
                if (in_valid && a_rdy) begin
                    b.c = in_ctrl; b.d = in_data; qa.push_back(b);
                end
            end
            z_has = (qz.size() != 0);
            z_rdy = !z_has || z_out_ready;
            if (z_has && !z_out_ready && !z_flush && cnt_z < 65535) cnt_z++;
            if (z_flush) qz.delete();
            else begin
                if (z_has && z_out_ready) void'(qz.pop_front());
                if (z_in_valid && z_rdy) begin
                    b.c = z_in_ctrl; b.d = z_in_data; qz.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic iv, input logic [CW-1:0] c, input logic orr, input logic fl);
        in_valid = iv; in_ctrl = c; in_data = dat_of(c); out_ready = orr; flush = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive_a(1'b0, '0, 1'b1, 1'b0);
        z_in_valid = 1'b0; z_in_ctrl = '0; z_in_data = '0; z_out_ready = 1'b1; z_flush = 1'b0;
        tick_pre(); tick_post();
        tick_pre(); tick_post();
        reset = 1'b0;

        // streaming 0x001..0x008
        for (int k = 0; k < 8; k++)
            tv.push_back(vec_t'{1'b1, CW'(k + 1), 1'b1, 1'b0, k > 0, CW'(k), 1'b1, 0});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b1, 14'h8,  1'b1, 0});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 0});
        // back-pressure: A then B to skid, C held upstream
        tv.push_back(vec_t'{1'b1, 14'hA,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 0});
        tv.push_back(vec_t'{1'b1, 14'hB,  1'b0, 1'b0, 1'b1, 14'hA,  1'b1, 0});
        tv.push_back(vec_t'{1'b1, 14'hC,  1'b0, 1'b0, 1'b1, 14'hA,  1'b0, 1});
        tv.push_back(vec_t'{1'b1, 14'hC,  1'b0, 1'b0, 1'b1, 14'hA,  1'b0, 2});
        tv.push_back(vec_t'{1'b1, 14'hC,  1'b1, 1'b0, 1'b1, 14'hA,  1'b0, 3});
        tv.push_back(vec_t'{1'b1, 14'hC,  1'b1, 1'b0, 1'b1, 14'hB,  1'b1, 3});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b1, 14'hC,  1'b1, 3});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 3});
        // flush with MAIN and SKB full and a beat offered
        tv.push_back(vec_t'{1'b1, 14'h11, 1'b0, 1'b0, 1'b0, 14'h0,  1'b1, 3});
        tv.push_back(vec_t'{1'b1, 14'h12, 1'b0, 1'b0, 1'b1, 14'h11, 1'b1, 3});
        tv.push_back(vec_t'{1'b1, 14'h13, 1'b0, 1'b1, 1'b1, 14'h11, 1'b0, 4});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 4});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 4});
        // flush while accepting: offered beat dropped
        tv.push_back(vec_t'{1'b1, 14'h14, 1'b1, 1'b1, 1'b0, 14'h0,  1'b1, 4});
        tv.push_back(vec_t'{1'b0, 14'h0,  1'b1, 1'b0, 1'b0, 14'h0,  1'b1, 4});

        foreach (tv[i]) begin
            drive_a(tv[i].iv, tv[i].c, tv[i].orr, tv[i].fl);
            tick_pre();
            chk($sformatf("tbl[%0d].out_valid", i), 128'(a_out_valid), 128'(tv[i].ov));
            chk($sformatf("tbl[%0d].out_ctrl", i),  128'(a_out_ctrl),  128'(tv[i].oc));
            chk($sformatf("tbl[%0d].in_ready", i),  128'(a_in_ready),  128'(tv[i].ir));
            chk($sformatf("tbl[%0d].stall", i),     128'(a_stall),     128'(tv[i].st));
            if (tv[i].ov)
                chk($sformatf("tbl[%0d].out_data", i), 128'(a_out_data), 128'(dat_of(tv[i].oc)));
            tick_post();
        end

        // reset for 2 cycles in the middle of stalled traffic
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, CW'(14'h20 + k), 1'b0, 1'b0);
            tick_pre(); tick_post();
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_a(1'b1, CW'(14'h30 + k), 1'b0, 1'b0);
            tick_pre(); tick_post();
        end
        reset = 1'b0;
        drive_a(1'b1, 14'h40, 1'b0, 1'b0);
        tick_pre();
        chk("rst.out_valid", 128'(a_out_valid), 128'(1'b0));
        chk("rst.out_ctrl",  128'(a_out_ctrl),  128'(0));
        chk("rst.out_data",  128'(a_out_data),  128'(0));
        chk("rst.stall",     128'(a_stall),     128'(0));
        chk("rst.in_ready",  128'(a_in_ready),  128'(1'b1));
        tick_post();

        // stall counter saturation: one beat held for 20 stalled cycles
        reset = 1'b1;
        tick_pre(); tick_post();
        reset = 1'b0;
        drive_a(1'b1, 14'h3, 1'b0, 1'b0);
        tick_pre(); tick_post();
        for (int k = 0; k < 20; k++) begin
            drive_a(1'b0, 14'h0, 1'b0, 1'b0);
            tick_pre(); tick_post();
        end
        tick_pre();
        chk("sat.s_stall", 128'(s_stall), 128'(15));
        chk("sat.a_stall", 128'(a_stall), 128'(20));
        tick_post();
        drive_a(1'b0, 14'h0, 1'b1, 1'b0);
        tick_pre(); tick_post();

        // SKID=0: out_ready toggling with in_valid held high
        for (int k = 0; k < 12; k++) begin
            z_in_valid = 1'b1; z_in_ctrl = CW'(k + 1); z_in_data = rnd_data();
            z_out_ready = (k % 2 == 0);
            tick_pre();
            if (qz.size() == 1) chk("z_in_ready_tracks", 128'(z_in_ready), 128'(z_out_ready));
            tick_post();
        end
        z_in_valid = 1'b0; z_out_ready = 1'b1;
        tick_pre(); tick_post();

        // randomized traffic on both configurations
        for (int k = 0; k < 800; k++) begin
            reset       = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_ctrl     = CW'($urandom);
            in_data     = rnd_data();
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 19) == 0);
            z_in_valid  = ($urandom_range(0, 9) < 7);
            z_in_ctrl   = CW'($urandom);
            z_in_data   = rnd_data();
            z_out_ready = ($urandom_range(0, 9) < 5);
            z_flush     = ($urandom_range(0, 19) == 0);
            tick_pre(); tick_post();
        end
        reset = 1'b0;
        tick_pre(); tick_post();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
